// File: rtl/tpu_mem_pkg.sv
// tpu_mem_pkg: shared constants, FSM state type and end-count helper for the memory read sequencer.
// Build option: MEM_RD_SKEW_EN selects the diagonal read skew across lanes; undefined gives all lanes in lockstep.
package tpu_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
`ifdef MEM_RD_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    // Final step count of a sequence: the skewed wavefront needs lanes-1 extra steps for the last lane to drain.
    function automatic int last_cnt(input int len, input int lanes, input bit skew);
        return skew ? len + lanes - 2 : len - 1;
    endfunction
endpackage

// File: rtl/rd_lane_gen.sv
// rd_lane_gen: combinational read enable and address for one lane at a given step count.
// Ports: cnt (step count), base_addr/len (latched request), stall -> rd_en, rd_addr.
// Build option: MEM_RD_SKEW_EN delays lane LANE by LANE steps.
module rd_lane_gen #(
    parameter int LANE   = 0,
    parameter int CNT_W  = 9,
    parameter int ADDR_W = tpu_mem_pkg::ADDR_W
) (
    input  logic [CNT_W-1:0]  cnt,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr
);
    import tpu_mem_pkg::*;
    logic [CNT_W-1:0] lo;
    logic             active;
    always_comb begin
        lo      = SKEW ? CNT_W'(LANE) : '0;
        active  = cnt >= lo && cnt < lo + CNT_W'(len);
        rd_en   = active && !stall;
        // truncation gives the modulo-2^ADDR_W address wrap
        rd_addr = active ? ADDR_W'(CNT_W'(base_addr) + cnt - lo) : '0;
    end
endmodule

// File: rtl/mem_rd_seq.sv
// mem_rd_seq: read sequencer issuing a per-lane read wavefront into the systolic array input memories.
// Ports: clk, rst_n (sync, active-low), start, base_addr, len, stall
//        -> rd_en[WIDTH_HEIGHT], rd_addr[WIDTH_HEIGHT*ADDR_W] (lane i at i*ADDR_W), rd_valid, busy, done.
// Build option: MEM_RD_SKEW_EN enables the diagonal skew (lane i starts i cycles after lane 0).
module mem_rd_seq #(
    parameter int WIDTH_HEIGHT = 4,
    parameter int ADDR_W       = tpu_mem_pkg::ADDR_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [ADDR_W-1:0]              len,
    input  logic                           stall,
    output logic [WIDTH_HEIGHT-1:0]        rd_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr,
    output logic [WIDTH_HEIGHT-1:0]        rd_valid,
    output logic                           busy,
    output logic                           done
);
    import tpu_mem_pkg::*;
    // wide enough to reach len + lanes without wrapping
    localparam int CNT_W = $clog2(2**ADDR_W + WIDTH_HEIGHT);
    state_t                         state;
    logic [CNT_W-1:0]               cnt;
    logic [ADDR_W-1:0]              base_r;
    logic [ADDR_W-1:0]              len_r;
    logic [WIDTH_HEIGHT-1:0]        lane_en;
    logic [WIDTH_HEIGHT*ADDR_W-1:0] lane_addr;
    logic                           last;
    assign last = cnt == CNT_W'(last_cnt(int'(len_r), WIDTH_HEIGHT, SKEW));
    for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_lane
        rd_lane_gen #(.LANE(i), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_lane (
            .cnt      (cnt),
            .base_addr(base_r),
            .len      (len_r),
            .stall    (stall),
            .rd_en    (lane_en[i]),
            .rd_addr  (lane_addr[i*ADDR_W +: ADDR_W])
        );
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            base_r   <= '0;
            len_r    <= '0;
            rd_en    <= '0;
            rd_addr  <= '0;
            rd_valid <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_r <= base_addr;
                    len_r  <= len;
                    cnt    <= '0;
                    state  <= len == '0 ? FIN : RUN;
                end
                RUN: if (!stall) begin
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIN;
                end
                default: state <= IDLE;
            endcase
            rd_en    <= state == RUN ? lane_en : '0;
            // a stall freezes the presented addresses rather than showing the next pending ones
            rd_addr  <= state != RUN ? '0 : stall ? rd_addr : lane_addr;
            rd_valid <= rd_en;
            busy     <= state == RUN;
            done     <= state == FIN;
        end
    end
endmodule

// File: tb/tb_mem_rd_seq.sv
// tb_mem_rd_seq: scoreboard bench for mem_rd_seq; expected per-cycle responses are queued at stimulus time.
module tb_mem_rd_seq;
    localparam int W  = 4;
    localparam int AW = 8;
`ifdef MEM_RD_SKEW_EN
    localparam bit SKEW = 1'b1;
`else
    localparam bit SKEW = 1'b0;
`endif
    typedef struct {int c; logic [W-1:0] en; logic [W*AW-1:0] a;} ev_t;
    typedef struct {int s; int e;} iv_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic [W-1:0]  rd_en;
    logic [W-1:0]  rd_valid;
    logic [W*AW-1:0] rd_addr;
    logic          busy;
    logic          done;

    mem_rd_seq #(.WIDTH_HEIGHT(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    ev_t  q[$];
    int   dq[$];
    iv_t  bq[$];
    int   rst_cyc = -1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, x);
        end
    endtask

    // Expected edge-by-edge response of one request accepted at edge t; nothing at or after cut is expected.
    task automatic plan(input int t, input logic [AW-1:0] b, input int l, input int sa, input int sn,
                        input int cut, output int fin);
        ev_t ev;
        int e = t + 1;
        int c = 0;
        int last = SKEW ? l + W - 2 : l - 1;
        logic [W*AW-1:0] pa = '0;
        if (l == 0) begin
            dq.push_back(t + 1);
            fin = t + 1;
            return;
        end
        while (c <= last) begin
            ev.c = e;
            ev.en = '0;
            ev.a = '0;
            if (e >= sa && e < sa + sn) ev.a = pa;
            else begin
                for (int i = 0; i < W; i++) begin
                    int lo = SKEW ? i : 0;
                    if (c >= lo && c < lo + l) begin
                        ev.en[i] = 1'b1;
                        ev.a[i*AW +: AW] = AW'(int'(b) + c - lo);
                    end
                end
                c++;
            end
            if (e < cut) q.push_back(ev);
            pa = ev.a;
            e++;
        end
        bq.push_back('{t + 1, (e - 1 < cut) ? e - 1 : cut - 1});
        if (e < cut) dq.push_back(e);
        fin = (e < cut) ? e : cut;
    endtask

    // so/sn: stall offset/length, ro: reset offset, ms: ignored-start offset (0 = none), all relative to accept edge
    task automatic go(input logic [AW-1:0] b, input int l, input int so, input int sn, input int ro, input int ms);
        int t = cyc + 1;
        int fin;
        base_addr = b;
        len = AW'(l);
        start = 1'b1;
        stall = 1'b0;
        if (ro > 0) rst_cyc = t + ro;
        plan(t, b, l, t + so, sn, ro > 0 ? t + ro : 1 << 30, fin);
        do begin
            @(negedge clk);
            start = ms > 0 && cyc == t + ms - 1;
            stall = sn > 0 && cyc >= t + so - 1 && cyc < t + so + sn - 1;
            rst_n = !(ro > 0 && cyc == t + ro - 1);
        end while (cyc < fin);
        start = 1'b0;
        stall = 1'b0;
    endtask

    logic [W-1:0] pen = '0;
    always @(negedge clk) begin
        logic [W-1:0]    xe;
        logic [W*AW-1:0] xa;
        logic            xd;
        logic            xb;
        if (cyc >= 1) begin
            xe = '0;
            xa = '0;
            if (q.size() > 0 && q[0].c == cyc) begin
                xe = q[0].en;
                xa = q[0].a;
                void'(q.pop_front());
            end
            xd = 1'b0;
            if (dq.size() > 0 && dq[0] == cyc) begin
                xd = 1'b1;
                void'(dq.pop_front());
            end
            while (bq.size() > 0 && bq[0].e < cyc) void'(bq.pop_front());
            xb = bq.size() > 0 && bq[0].s <= cyc;
            chk("rd_en", 32'(rd_en), 32'(xe));
            chk("rd_addr", rd_addr, xa);
            chk("rd_valid", 32'(rd_valid), cyc == rst_cyc ? 32'd0 : 32'(pen));
            chk("busy", 32'(busy), 32'(xb));
            chk("done", 32'(done), 32'(xd));
            pen = xe;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(8'h10, 3, 0, 0, 0, 0);
        go(8'hFE, 4, 0, 0, 0, 0);
        @(negedge clk);
        go(8'h20, 5, 3, 2, 0, 0);
        go(8'h40, 0, 0, 0, 0, 0);
        go(8'h50, 4, 0, 0, 0, 2);
        @(negedge clk);
        go(8'h60, 6, 0, 0, 2, 0);
        go(8'h70, 3, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() + dq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", q.size() + dq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
